axi_mst_rd_ctrl: RTL and testbench

AXI read master controller. It converts a simple user read-request interface into AXI AR transactions and returns the R-channel beats to the user through a registered result port. Up to `AXI_RD_OST_NUM` bursts can be outstanding at once, each tagged with a unique ARID equal to its tracking-slot index. It is the initiator-side counterpart of the slave read controller on the same AXI fabric.

---
 rtl/axi_mst_rd_ctrl_if.sv | 115 +++++++++++
 rtl/axi_mst_rd_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_axi_mst_rd_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mst_rd_ctrl_if.sv
// ============================================================================
// axi_mst_rd_ctrl_if : user request/result, status and AXI AR/R signal bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif

interface axi_mst_rd_ctrl_if #(
  parameter int AXI_RD_OST_NUM = 8
);
  localparam int CNT_W = $clog2(AXI_RD_OST_NUM) + 1;

  logic                          rd_req_valid;
  logic                          rd_req_ready;
  logic [`AXI_ADDR_WIDTH-1:0]    rd_req_addr;
  logic [`AXI_LEN_WIDTH-1:0]     rd_req_len;
  logic [`AXI_SIZE_WIDTH-1:0]    rd_req_size;
  logic [`AXI_BURST_WIDTH-1:0]   rd_req_burst;

  logic                          rd_result_valid;
  logic                          rd_result_ready;
  logic [`AXI_ID_WIDTH-1:0]      rd_result_id;
  logic [`AXI_DATA_WIDTH-1:0]    rd_result_data;
  logic [`AXI_RESP_WIDTH-1:0]    rd_result_resp;
  logic                          rd_result_last;

  logic [CNT_W-1:0]              rd_ost_cnt;
  logic                          rd_err;

  logic                          axi_mst_arvalid;
  logic                          axi_mst_arready;
  logic [`AXI_ID_WIDTH-1:0]      axi_mst_arid;
  logic [`AXI_ADDR_WIDTH-1:0]    axi_mst_araddr;
  logic [`AXI_LEN_WIDTH-1:0]     axi_mst_arlen;
  logic [`AXI_SIZE_WIDTH-1:0]    axi_mst_arsize;
  logic [`AXI_BURST_WIDTH-1:0]   axi_mst_arburst;
  logic [`AXI_LOCK_WIDTH-1:0]    axi_mst_arlock;
  logic [`AXI_CACHE_WIDTH-1:0]   axi_mst_arcache;
  logic [`AXI_PROT_WIDTH-1:0]    axi_mst_arprot;
  logic [`AXI_QOS_WIDTH-1:0]     axi_mst_arqos;
  logic [`AXI_REGION_WIDTH-1:0]  axi_mst_arregion;

  logic                          axi_mst_rvalid;
  logic                          axi_mst_rready;
  logic [`AXI_ID_WIDTH-1:0]      axi_mst_rid;
  logic [`AXI_DATA_WIDTH-1:0]    axi_mst_rdata;
  logic [`AXI_RESP_WIDTH-1:0]    axi_mst_rresp;
  logic                          axi_mst_rlast;

  modport master (
    input  rd_req_valid, rd_req_addr, rd_req_len, rd_req_size, rd_req_burst,
    output rd_req_ready,
    output rd_result_valid, rd_result_id, rd_result_data, rd_result_resp, rd_result_last,
    input  rd_result_ready,
    output rd_ost_cnt, rd_err,
    output axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen, axi_mst_arsize,
    output axi_mst_arburst, axi_mst_arlock, axi_mst_arcache, axi_mst_arprot, axi_mst_arqos,
    output axi_mst_arregion,
    input  axi_mst_arready,
    input  axi_mst_rvalid, axi_mst_rid, axi_mst_rdata, axi_mst_rresp, axi_mst_rlast,
    output axi_mst_rready
  );

  modport slave (
    output rd_req_valid, rd_req_addr, rd_req_len, rd_req_size, rd_req_burst,
    input  rd_req_ready,
    input  rd_result_valid, rd_result_id, rd_result_data, rd_result_resp, rd_result_last,
    output rd_result_ready,
    input  rd_ost_cnt, rd_err,
    input  axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen, axi_mst_arsize,
    input  axi_mst_arburst, axi_mst_arlock, axi_mst_arcache, axi_mst_arprot, axi_mst_arqos,
    input  axi_mst_arregion,
    output axi_mst_arready,
    output axi_mst_rvalid, axi_mst_rid, axi_mst_rdata, axi_mst_rresp, axi_mst_rlast,
    input  axi_mst_rready
  );
endinterface

`default_nettype wire

// File: rtl/axi_mst_rd_ctrl.sv
// ============================================================================
// axi_mst_rd_ctrl : AXI read master, slot-tracked outstanding bursts
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_mst_rd_ctrl #(
  parameter int AXI_RD_OST_NUM = 8
) (
  input  logic              clk,
  input  logic              rst,
  axi_mst_rd_ctrl_if.master bus
);
  localparam int OST   = AXI_RD_OST_NUM;
  localparam int IDX_W = (OST > 1) ? $clog2(OST) : 1;
  localparam int CNT_W = $clog2(OST) + 1;
  localparam int ID_W  = `AXI_ID_WIDTH;
  localparam int LEN_W = `AXI_LEN_WIDTH;
  localparam int BC_W  = LEN_W + 1;

  logic [OST-1:0]               busy_q, busy_d;
  logic [LEN_W-1:0]             len_q [OST];
  logic [LEN_W-1:0]             len_d [OST];
  logic [BC_W-1:0]              cnt_q [OST];
  logic [BC_W-1:0]              cnt_d [OST];
  logic [CNT_W-1:0]             ost_q, ost_d;
  logic                         err_q, err_d;

  logic                         arvalid_q, arvalid_d;
  logic [ID_W-1:0]              arid_q, arid_d;
  logic [`AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [LEN_W-1:0]             arlen_q, arlen_d;
  logic [`AXI_SIZE_WIDTH-1:0]   arsize_q, arsize_d;
  logic [`AXI_BURST_WIDTH-1:0]  arburst_q, arburst_d;

  logic                         res_valid_q, res_valid_d;
  logic [ID_W-1:0]              res_id_q, res_id_d;
  logic [`AXI_DATA_WIDTH-1:0]   res_data_q, res_data_d;
  logic [`AXI_RESP_WIDTH-1:0]   res_resp_q, res_resp_d;
  logic                         res_last_q, res_last_d;

  logic [IDX_W-1:0]             free_idx;
  logic                         any_free;
  logic                         req_ready;
  logic                         req_acc;
  logic                         rready;
  logic                         r_hs;
  logic                         rid_ok;
  logic [IDX_W-1:0]             rslot;
  logic                         slot_free;

  // Lowest-index free slot, taken from registered busy bits only.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = OST - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

  assign req_ready = (~arvalid_q | bus.axi_mst_arready) & any_free;
  assign req_acc   = bus.rd_req_valid & req_ready;
  assign rready    = ~res_valid_q | bus.rd_result_ready;
  assign r_hs      = bus.axi_mst_rvalid & rready;
  assign rid_ok    = 32'(bus.axi_mst_rid) < 32'(OST);
  assign rslot     = bus.axi_mst_rid[IDX_W-1:0];
  assign slot_free = r_hs & bus.axi_mst_rlast & rid_ok & busy_q[rslot];

  always_comb begin
    busy_d      = busy_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    arvalid_d   = arvalid_q;
    arid_d      = arid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_resp_d  = res_resp_q;
    res_last_d  = res_last_q;

    if (bus.axi_mst_arready) begin
      arvalid_d = 1'b0;
    end
    if (req_acc) begin
      busy_d[free_idx] = 1'b1;
      len_d[free_idx]  = bus.rd_req_len;
      cnt_d[free_idx]  = '0;
      arvalid_d        = 1'b1;
      arid_d           = ID_W'(free_idx);
      araddr_d         = bus.rd_req_addr;
      arlen_d          = bus.rd_req_len;
      arsize_d         = bus.rd_req_size;
      arburst_d        = bus.rd_req_burst;
    end

    // A freed slot is always busy here, so it never collides with free_idx.
    if (r_hs) begin
      res_valid_d = 1'b1;
      res_id_d    = bus.axi_mst_rid;
      res_data_d  = bus.axi_mst_rdata;
      res_resp_d  = bus.axi_mst_rresp;
      res_last_d  = bus.axi_mst_rlast;
      if (!rid_ok || !busy_q[rslot]) begin
        err_d = 1'b1;
      end else begin
        if (bus.axi_mst_rlast != (cnt_q[rslot] == {1'b0, len_q[rslot]})) begin
          err_d = 1'b1;
        end
        cnt_d[rslot] = cnt_q[rslot] + BC_W'(1);
        if (bus.axi_mst_rlast) begin
          busy_d[rslot] = 1'b0;
        end
      end
    end else if (bus.rd_result_ready) begin
      res_valid_d = 1'b0;
    end

    ost_d = ost_q + CNT_W'(req_acc) - CNT_W'(slot_free);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      for (int i = 0; i < OST; i++) begin
        len_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      ost_q       <= '0;
      err_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      arid_q      <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      res_resp_q  <= '0;
      res_last_q  <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ost_q       <= ost_d;
      err_q       <= err_d;
      arvalid_q   <= arvalid_d;
      arid_q      <= arid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_resp_q  <= res_resp_d;
      res_last_q  <= res_last_d;
    end
  end

  assign bus.rd_req_ready     = req_ready;
  assign bus.axi_mst_rready   = rready;
  assign bus.rd_ost_cnt       = ost_q;
  assign bus.rd_err           = err_q;
  assign bus.axi_mst_arvalid  = arvalid_q;
  assign bus.axi_mst_arid     = arid_q;
  assign bus.axi_mst_araddr   = araddr_q;
  assign bus.axi_mst_arlen    = arlen_q;
  assign bus.axi_mst_arsize   = arsize_q;
  assign bus.axi_mst_arburst  = arburst_q;
  assign bus.axi_mst_arlock   = '0;
  assign bus.axi_mst_arcache  = '0;
  assign bus.axi_mst_arprot   = '0;
  assign bus.axi_mst_arqos    = '0;
  assign bus.axi_mst_arregion = '0;
  assign bus.rd_result_valid  = res_valid_q;
  assign bus.rd_result_id     = res_id_q;
  assign bus.rd_result_data   = res_data_q;
  assign bus.rd_result_resp   = res_resp_q;
  assign bus.rd_result_last   = res_last_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_mst_rd_ctrl.sv
// ============================================================================
// tb_axi_mst_rd_ctrl : randomized AXI slave + reference model for axi_mst_rd_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_mst_rd_ctrl;
  localparam int OST = 8;
  localparam int IDW = `AXI_ID_WIDTH;
  localparam int AW  = `AXI_ADDR_WIDTH;
  localparam int LW  = `AXI_LEN_WIDTH;
  localparam int DW  = `AXI_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_mst_rd_ctrl_if #(.AXI_RD_OST_NUM(OST)) bus ();
  axi_mst_rd_ctrl #(.AXI_RD_OST_NUM(OST)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  len;
    logic [2:0]     size;
    logic [1:0]     burst;
  } ar_t;
  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } rb_t;

  // Reference model: which bursts are outstanding and what the user must see.
  bit  m_busy [OST];
  int  m_len  [OST];
  int  m_cnt  [OST];
  bit  m_err;
  ar_t arq[$];
  rb_t resq[$];
  // Slave-side view of bursts it owes data for.
  bit  sl_act  [OST];
  int  sl_len  [OST];
  int  sl_beat [OST];
  bit  req_hs, r_hs;
  // Stimulus knobs.
  int  p_arready = 100, p_rvalid = 100, p_rres = 100, force_id = -1;
  bit  early_last = 0, manual_r = 0;

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < OST; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Monitor: check outputs against the model, then apply this cycle's handshakes.
  initial begin
    forever begin
      int  nb, slot;
      bit  found;
      ar_t a;
      rb_t b;
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < OST; i++) begin
          m_busy[i] = 0; m_cnt[i] = 0; sl_act[i] = 0;
        end
        m_err = 0; arq.delete(); resq.delete(); req_hs = 0; r_hs = 0;
        continue;
      end
      nb = busy_count();
      check_val("ost_cnt", 64'(bus.rd_ost_cnt), 64'(nb));
      check_val("rd_err", 64'(bus.rd_err), 64'(m_err));
      check_val("req_ready", 64'(bus.rd_req_ready),
                64'((arq.size() == 0 || bus.axi_mst_arready) && nb < OST));
      check_val("rready", 64'(bus.axi_mst_rready), 64'(resq.size() == 0 || bus.rd_result_ready));
      check_val("arvalid", 64'(bus.axi_mst_arvalid), 64'(arq.size() > 0));
      check_val("ar_tied", 64'({bus.axi_mst_arlock, bus.axi_mst_arcache, bus.axi_mst_arprot,
                                bus.axi_mst_arqos, bus.axi_mst_arregion}), 64'd0);
      if (arq.size() > 0)
        check_val("ar_payload", 64'({bus.axi_mst_arid, bus.axi_mst_araddr, bus.axi_mst_arlen,
                                     bus.axi_mst_arsize, bus.axi_mst_arburst}),
                  64'({arq[0].id, arq[0].addr, arq[0].len, arq[0].size, arq[0].burst}));
      check_val("res_valid", 64'(bus.rd_result_valid), 64'(resq.size() > 0));
      if (resq.size() > 0)
        check_val("res_beat", 64'({bus.rd_result_id, bus.rd_result_data, bus.rd_result_resp,
                                   bus.rd_result_last}),
                  64'({resq[0].id, resq[0].data, resq[0].resp, resq[0].last}));

      req_hs = bus.rd_req_valid & bus.rd_req_ready;
      r_hs   = bus.axi_mst_rvalid & bus.axi_mst_rready;

      if (bus.axi_mst_arvalid && bus.axi_mst_arready && arq.size() > 0) begin
        a = arq.pop_front();
        sl_act[a.id] = 1; sl_len[a.id] = int'(a.len); sl_beat[a.id] = 0;
      end
      if (bus.rd_result_valid && bus.rd_result_ready && resq.size() > 0) void'(resq.pop_front());
      // Allocation sees slot state from before this cycle's frees.
      if (req_hs) begin
        found = 0; slot = 0;
        for (int i = 0; i < OST; i++)
          if (!found && !m_busy[i]) begin found = 1; slot = i; end
        check_val("alloc_slot_found", 64'(found), 64'd1);
        m_busy[slot] = 1; m_len[slot] = int'(bus.rd_req_len); m_cnt[slot] = 0;
        a.id = IDW'(slot); a.addr = bus.rd_req_addr; a.len = bus.rd_req_len;
        a.size = bus.rd_req_size; a.burst = bus.rd_req_burst;
        arq.push_back(a);
      end
      if (r_hs) begin
        b.id = bus.axi_mst_rid; b.data = bus.axi_mst_rdata;
        b.resp = bus.axi_mst_rresp; b.last = bus.axi_mst_rlast;
        resq.push_back(b);
        slot = int'(bus.axi_mst_rid);
        if (slot >= OST || !m_busy[slot]) m_err = 1;
        else begin
          if (bus.axi_mst_rlast != (m_cnt[slot] == m_len[slot])) m_err = 1;
          m_cnt[slot]++;
          if (bus.axi_mst_rlast) m_busy[slot] = 0;
        end
        if (slot < OST && sl_act[slot]) begin
          sl_beat[slot]++;
          if (bus.axi_mst_rlast) sl_act[slot] = 0;
        end
      end
    end
  end

  // AXI slave and result consumer.
  initial begin
    int cand[$];
    int id;
    bus.axi_mst_arready = 0; bus.axi_mst_rvalid = 0; bus.axi_mst_rid = '0;
    bus.axi_mst_rdata = '0; bus.axi_mst_rresp = '0; bus.axi_mst_rlast = 0;
    bus.rd_result_ready = 1;
    forever begin
      @(posedge clk); #1;
      bus.axi_mst_arready = ($urandom_range(99) < p_arready);
      bus.rd_result_ready = ($urandom_range(99) < p_rres);
      if (manual_r) continue;
      id = int'(bus.axi_mst_rid);
      if (rst || !bus.axi_mst_rvalid || r_hs || id >= OST || !sl_act[id]) begin
        bus.axi_mst_rvalid = 0;
        cand.delete();
        for (int i = 0; i < OST; i++)
          if (sl_act[i] && (force_id < 0 || force_id == i)) cand.push_back(i);
        if (!rst && cand.size() > 0 && $urandom_range(99) < p_rvalid) begin
          id = cand[$urandom_range(cand.size() - 1)];
          bus.axi_mst_rvalid = 1;
          bus.axi_mst_rid    = IDW'(id);
          bus.axi_mst_rdata  = DW'($urandom);
          bus.axi_mst_rresp  = 2'($urandom_range(3));
          bus.axi_mst_rlast  = (sl_beat[id] == sl_len[id]) || (early_last && sl_beat[id] == 1);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; cyc(1); rst = 0;
  endtask

  task automatic send_req(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    bit ok = 0;
    bus.rd_req_valid = 1; bus.rd_req_addr = addr; bus.rd_req_len = len;
    bus.rd_req_size = 3'd2; bus.rd_req_burst = 2'd1;
    for (int i = 0; i < 300 && !ok; i++) begin cyc(1); ok = req_hs; end
    check_val("req_accepted", 64'(ok), 64'd1);
    bus.rd_req_valid = 0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    bus.rd_req_valid = 0;
    while ((busy_count() != 0 || arq.size() != 0 || resq.size() != 0) && k < 3000) begin
      cyc(1); k++;
    end
    check_val(tag, 64'(busy_count() + arq.size() + resq.size()), 64'd0);
    check_val({tag, "_ost"}, 64'(bus.rd_ost_cnt), 64'd0);
  endtask

  initial begin
    bit ok;
    bus.rd_req_valid = 0; bus.rd_req_addr = '0; bus.rd_req_len = '0;
    bus.rd_req_size = '0; bus.rd_req_burst = '0;
    rst = 1; cyc(3); rst = 0;
    check_val("rst_ar", 64'({bus.axi_mst_arvalid, bus.axi_mst_arid, bus.axi_mst_araddr,
                             bus.axi_mst_arlen, bus.axi_mst_arsize, bus.axi_mst_arburst}), 64'd0);
    check_val("rst_res", 64'({bus.rd_result_valid, bus.rd_result_id, bus.rd_result_data,
                              bus.rd_result_resp, bus.rd_result_last}), 64'd0);
    check_val("rst_status", 64'({bus.rd_err, bus.rd_ost_cnt}), 64'd0);
    check_val("rst_ready", 64'({bus.rd_req_ready, bus.axi_mst_rready}), 64'b11);

    // Single burst.
    send_req(32'h100, 8'd3);
    check_val("single_arid_len", 64'({bus.axi_mst_arvalid, bus.axi_mst_arid, bus.axi_mst_arlen}),
              64'({1'b1, 4'd0, 8'd3}));
    drain("single_drain");

    // Fill to full, then free slot 5 and reuse it.
    p_rvalid = 0;
    for (int i = 0; i < OST; i++) send_req(AW'(32'h1000 + i * 64), LW'(i % 4));
    check_val("full_ost", 64'(bus.rd_ost_cnt), 64'(OST));
    check_val("full_ready", 64'(bus.rd_req_ready), 64'd0);
    force_id = 5; p_rvalid = 100; ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin cyc(1); ok = !m_busy[5]; end
    check_val("slot5_freed", 64'(ok), 64'd1);
    check_val("full_ready_back", 64'(bus.rd_req_ready), 64'd1);
    send_req(32'h2000, 8'd2);
    check_val("reuse_arid5", 64'(bus.axi_mst_arid), 64'd5);
    force_id = -1;
    drain("fill_drain");

    // AR stall, then result backpressure on an interleaved pair.
    p_arready = 0;
    send_req(32'h300, 8'd1);
    bus.rd_req_valid = 1; bus.rd_req_addr = 32'h400; bus.rd_req_len = 8'd1;
    cyc(5);
    check_val("stall_arvalid", 64'(bus.axi_mst_arvalid), 64'd1);
    p_arready = 100;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin cyc(1); ok = req_hs; end
    check_val("stall_req2", 64'(ok), 64'd1);
    bus.rd_req_valid = 0;
    p_rres = 30;
    drain("ooo_drain");
    p_rres = 100;

    // Stray beat on an idle slot.
    p_rvalid = 0; cyc(2);
    manual_r = 1; cyc(1);
    bus.axi_mst_rvalid = 1; bus.axi_mst_rid = IDW'(3); bus.axi_mst_rlast = 1;
    bus.axi_mst_rdata = DW'(32'hDEAD_BEEF);
    cyc(1);
    bus.axi_mst_rvalid = 0; manual_r = 0;
    cyc(3);
    check_val("err_idle_slot", 64'(bus.rd_err), 64'd1);
    do_reset(); cyc(1);
    check_val("err_cleared", 64'(bus.rd_err), 64'd0);

    // Early rlast on len=3.
    p_rvalid = 100; early_last = 1;
    send_req(32'h500, 8'd3);
    drain("early_drain");
    check_val("err_early_last", 64'(bus.rd_err), 64'd1);
    early_last = 0;
    do_reset(); cyc(1);
    check_val("err_cleared2", 64'(bus.rd_err), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) begin
        p_arready = $urandom_range(30, 100);
        p_rvalid  = $urandom_range(30, 100);
        p_rres    = $urandom_range(30, 100);
      end
      if (!bus.rd_req_valid || req_hs) begin
        bus.rd_req_valid = ($urandom_range(99) < 50);
        bus.rd_req_addr  = AW'($urandom);
        bus.rd_req_len   = LW'($urandom_range(0, 7));
        bus.rd_req_size  = 3'($urandom_range(0, 2));
        bus.rd_req_burst = 2'($urandom_range(0, 2));
      end
      cyc(1);
    end
    p_rvalid = 100; p_rres = 100; p_arready = 100;
    drain("rand_drain");
    check_val("rand_no_err", 64'(bus.rd_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
